// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: reg_file reads, EX/MEM forwarding, load-use stall into the ID/EX register.
// Latency 1 cycle in to out; holds while out_ready=0 and drops in_ready on hazard, hold or flush.
module id_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic              in_use_rs,
  input  logic              in_use_rt,
  input  logic [4:0]        in_rd,
  input  logic              in_wr_rd,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] in_imm,
  output logic              r1_en,
  output logic              r2_en,
  output logic [4:0]        r1_addr,
  output logic [4:0]        r2_addr,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [DATA_W-1:0] r2_data,
  input  logic              ex_wr_en,
  input  logic [4:0]        ex_wr_addr,
  input  logic [DATA_W-1:0] ex_wr_data,
  input  logic              ex_is_load,
  input  logic              mem_wr_en,
  input  logic [4:0]        mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_rd,
  output logic              out_wr_rd,
  output logic              out_is_load,
  output logic [DATA_W-1:0] out_imm,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              hazard, adv, load, bump;
  logic [DATA_W-1:0] op_a, op_b;

  // A loaded value still in EX cannot be forwarded; that case is the load-use stall instead.
  function automatic logic [DATA_W-1:0] pick(
    input logic              use_src,
    input logic [4:0]        src,
    input logic [DATA_W-1:0] rf_val,
    input logic              ex_en,
    input logic              ex_ld,
    input logic [4:0]        ex_addr,
    input logic [DATA_W-1:0] ex_data,
    input logic              mem_en,
    input logic [4:0]        mem_addr,
    input logic [DATA_W-1:0] mem_data
  );
    if (!use_src || src == 5'd0)                return '0;
    else if (ex_en && !ex_ld && ex_addr == src) return ex_data;
    else if (mem_en && mem_addr == src)         return mem_data;
    else                                        return rf_val;
  endfunction

  assign r1_en   = in_valid & in_use_rs;
  assign r2_en   = in_valid & in_use_rt;
  assign r1_addr = in_rs;
  assign r2_addr = in_rt;

  assign op_a = pick(in_use_rs, in_rs, r1_data, ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
                     mem_wr_en, mem_wr_addr, mem_wr_data);
  assign op_b = pick(in_use_rt, in_rt, r2_data, ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
                     mem_wr_en, mem_wr_addr, mem_wr_data);

  assign hazard = in_valid & ex_wr_en & ex_is_load & (ex_wr_addr != 5'd0) &
                  ((in_use_rs & (in_rs == ex_wr_addr)) | (in_use_rt & (in_rt == ex_wr_addr)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                      state_d = EMPTY;
    else if (adv && in_valid && !hazard) state_d = FULL;
    else if (adv)                   state_d = EMPTY;
  end

  always_comb begin
    out_valid = (state_q == FULL);
    adv       = out_ready | ~out_valid;
    in_ready  = adv & ~hazard & ~flush;
    load      = ~flush & adv & in_valid & ~hazard;
    bump      = ~flush & adv & hazard;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_a       <= '0;
      out_b       <= '0;
      out_rd      <= '0;
      out_wr_rd   <= 1'b0;
      out_is_load <= 1'b0;
      out_imm     <= '0;
    end else if (load) begin
      out_a       <= op_a;
      out_b       <= op_b;
      out_rd      <= in_rd;
      out_wr_rd   <= in_wr_rd;
      out_is_load <= in_is_load;
      out_imm     <= in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stall_cnt <= '0;
    else if (bump && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed and randomized checks of id_operand_fetch against a cycle-level reference model.
module tb_id_operand_fetch;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready;
  logic [4:0] in_rs, in_rt, in_rd;
  logic in_use_rs, in_use_rt, in_wr_rd, in_is_load;
  logic [DW-1:0] in_imm;
  logic r1_en, r2_en;
  logic [4:0] r1_addr, r2_addr;
  logic [DW-1:0] r1_data, r2_data;
  logic ex_wr_en, ex_is_load, mem_wr_en;
  logic [4:0] ex_wr_addr, mem_wr_addr;
  logic [DW-1:0] ex_wr_data, mem_wr_data;
  logic out_valid, out_ready, out_wr_rd, out_is_load;
  logic [DW-1:0] out_a, out_b, out_imm;
  logic [4:0] out_rd;
  logic [CW-1:0] stall_cnt;

  logic [DW-1:0] rf [32];
  assign r1_data = rf[r1_addr];
  assign r2_data = rf[r2_addr];

  id_operand_fetch #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
    .in_rd(in_rd), .in_wr_rd(in_wr_rd), .in_is_load(in_is_load), .in_imm(in_imm),
    .r1_en(r1_en), .r2_en(r2_en), .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_data(r1_data), .r2_data(r2_data),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_wr_rd(out_wr_rd), .out_is_load(out_is_load), .out_imm(out_imm),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state of the ID/EX register.
  logic          m_valid, m_wr_rd, m_is_load;
  logic [DW-1:0] m_a, m_b, m_imm;
  logic [4:0]    m_rd;
  int            m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic use_s, input logic [4:0] s);
    if (!use_s || s == 0) return '0;
    if (ex_wr_en && !ex_is_load && ex_wr_addr == s) return ex_wr_data;
    if (mem_wr_en && mem_wr_addr == s) return mem_wr_data;
    return rf[s];
  endfunction

  task automatic idle();
    flush = 0; in_valid = 0; in_rs = 0; in_rt = 0; in_use_rs = 0; in_use_rt = 0;
    in_rd = 0; in_wr_rd = 0; in_is_load = 0; in_imm = 0;
    ex_wr_en = 0; ex_wr_addr = 0; ex_wr_data = 0; ex_is_load = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_wr_data = 0; out_ready = 1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_a = 0; m_b = 0; m_imm = 0; m_rd = 0; m_wr_rd = 0; m_is_load = 0; m_cnt = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_a"}, 64'(out_a), 64'd0);
    chk({tag, "_b"}, 64'(out_b), 64'd0);
    chk({tag, "_imm"}, 64'(out_imm), 64'd0);
    chk({tag, "_rd"}, 64'(out_rd), 64'd0);
    chk({tag, "_wrrd"}, 64'(out_wr_rd), 64'd0);
    chk({tag, "_isld"}, 64'(out_is_load), 64'd0);
    chk({tag, "_cnt"}, 64'(stall_cnt), 64'd0);
  endtask

  // Called just after a falling edge with inputs already applied; returns after the next falling edge.
  task automatic step();
    logic hz, adv;
    logic [DW-1:0] a, b;
    #1;
    hz  = in_valid && ex_wr_en && ex_is_load && ex_wr_addr != 0 &&
          ((in_use_rs && in_rs == ex_wr_addr) || (in_use_rt && in_rt == ex_wr_addr));
    adv = out_ready || !m_valid;
    chk("in_ready", 64'(in_ready), 64'(adv && !hz && !flush));
    chk("r1_en", 64'(r1_en), 64'(in_valid && in_use_rs));
    chk("r2_en", 64'(r2_en), 64'(in_valid && in_use_rt));
    chk("r1_addr", 64'(r1_addr), 64'(in_rs));
    chk("r2_addr", 64'(r2_addr), 64'(in_rt));
    a = ref_op(in_use_rs, in_rs);
    b = ref_op(in_use_rt, in_rt);
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (adv) begin
      if (in_valid && !hz) begin
        m_valid = 1; m_a = a; m_b = b; m_rd = in_rd; m_wr_rd = in_wr_rd;
        m_is_load = in_is_load; m_imm = in_imm;
      end else begin
        m_valid = 0;
        if (hz && m_cnt < CMAX) m_cnt++;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (m_valid) begin
      chk("out_a", 64'(out_a), 64'(m_a));
      chk("out_b", 64'(out_b), 64'(m_b));
      chk("out_rd", 64'(out_rd), 64'(m_rd));
      chk("out_wr_rd", 64'(out_wr_rd), 64'(m_wr_rd));
      chk("out_is_load", 64'(out_is_load), 64'(m_is_load));
      chk("out_imm", 64'(out_imm), 64'(m_imm));
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    idle();
    rst = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1;

    // Plain register-file read.
    in_valid = 1; in_rs = 3; in_rt = 4; in_use_rs = 1; in_use_rt = 1;
    in_rd = 5; in_wr_rd = 1; in_imm = 32'd123;
    step();
    chk("t1_a", 64'(out_a), 64'h11);
    chk("t1_b", 64'(out_b), 64'h22);
    chk("t1_v", 64'(out_valid), 64'd1);

    // EX beats MEM, then MEM alone.
    ex_wr_en = 1; ex_wr_addr = 3; ex_wr_data = 32'hAA;
    mem_wr_en = 1; mem_wr_addr = 3; mem_wr_data = 32'hBB;
    step();
    chk("ex_over_mem", 64'(out_a), 64'hAA);
    ex_wr_en = 0;
    step();
    chk("mem_fwd", 64'(out_a), 64'hBB);

    // Load-use stall on rt, then proceed once the load leaves EX.
    idle();
    in_valid = 1; in_use_rt = 1; in_rt = 4;
    ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4; ex_wr_data = 32'h99;
    step();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    chk("lu_cnt", 64'(stall_cnt), 64'd1);
    ex_wr_en = 0; ex_is_load = 0;
    step();
    chk("lu_go", 64'(out_valid), 64'd1);
    chk("lu_b", 64'(out_b), 64'h22);

    // Register 0 never forwards.
    idle();
    in_valid = 1; in_use_rs = 1; in_rs = 0;
    ex_wr_en = 1; ex_wr_addr = 0; ex_wr_data = 32'h55;
    step();
    chk("r0_a", 64'(out_a), 64'd0);

    // Hold under backpressure, then flush during hold.
    idle();
    in_valid = 1; in_use_rs = 1; in_rs = 3;
    step();
    out_ready = 0; in_rs = 4; in_imm = 32'h77;
    step();
    chk("hold_a", 64'(out_a), 64'h11);
    chk("hold_v", 64'(out_valid), 64'd1);
    flush = 1;
    step();
    chk("flush_v", 64'(out_valid), 64'd0);

    // Saturate the stall counter.
    idle();
    in_valid = 1; in_use_rt = 1; in_rt = 4; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4;
    for (int i = 0; i < CMAX + 5; i++) step();
    chk("sat_cnt", 64'(stall_cnt), 64'(CMAX));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      flush       = ($urandom_range(0, 19) == 0);
      in_valid    = ($urandom_range(0, 4) != 0);
      in_rs       = 5'($urandom_range(0, 5));
      in_rt       = 5'($urandom_range(0, 5));
      in_use_rs   = 1'($urandom);
      in_use_rt   = 1'($urandom);
      in_rd       = 5'($urandom);
      in_wr_rd    = 1'($urandom);
      in_is_load  = 1'($urandom);
      in_imm      = $urandom;
      ex_wr_en    = 1'($urandom);
      ex_wr_addr  = 5'($urandom_range(0, 5));
      ex_wr_data  = $urandom;
      ex_is_load  = ($urandom_range(0, 3) == 0);
      mem_wr_en   = 1'($urandom);
      mem_wr_addr = 5'($urandom_range(0, 5));
      mem_wr_data = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset while holding a full register.
    idle();
    in_valid = 1; in_use_rs = 1; in_rs = 3; in_imm = 32'h5;
    step();
    out_ready = 0;
    step();
    rst = 0;
    #2;
    chk_zero("arst");
    model_reset();
    @(negedge clk);
    rst = 1;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
